// File: rtl/lcd_pkg.sv
// LCD controller shared definitions: address map, control bits, scan geometry.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package lcd_pkg;

  // Bus address map
  localparam logic [11:0] SEG0_BASE = 12'hE00;
  localparam logic [11:0] SEG1_BASE = 12'hE80;
  localparam logic [11:0] CTRL_ADDR = 12'hF71;
  localparam logic [11:0] SEG_SPAN  = 12'h050;

  // Offsets inside a segment
  localparam logic [6:0] ICON_LO_OFS = 7'h40;
  localparam logic [6:0] ICON_HI_OFS = 7'h41;

  // Control register bit positions (bits 1:0 are plain storage)
  localparam int CTRL_ALOFF = 3;
  localparam int CTRL_ALON  = 2;

  // Geometry and widths
  localparam int NIB_W      = 4;
  localparam int X_W        = 5;
  localparam int Y_W        = 4;
  localparam int ICON_W     = 8;
  localparam int SEG_DEPTH  = 80;
  localparam int VRAM_DEPTH = 2 * SEG_DEPTH;
  localparam int VRAM_AW    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    ICONS = 2'd3
  } lcd_state_e;

  // Result of decoding a bus address against the two display segments
  typedef struct packed {
    logic       hit;
    logic       seg;
    logic [6:0] ofs;
  } vram_dec_t;

  // Display segment decode; the 12-bit subtraction wraps for addresses below
  // a base, so a single unsigned compare gives the in-window test.
  function automatic vram_dec_t decode_vram(input logic [11:0] addr);
    vram_dec_t dec;
    dec = '0;
    if ((addr - SEG0_BASE) < SEG_SPAN) begin
      dec.hit = 1'b1;
      dec.seg = 1'b0;
      dec.ofs = 7'(addr - SEG0_BASE);
    end else if ((addr - SEG1_BASE) < SEG_SPAN) begin
      dec.hit = 1'b1;
      dec.seg = 1'b1;
      dec.ofs = 7'(addr - SEG1_BASE);
    end
    return dec;
  endfunction

  // Flat VRAM word index: segment 1 lives above the 80 words of segment 0
  function automatic logic [VRAM_AW-1:0] vram_index(input logic seg, input logic [6:0] ofs);
    return seg ? (VRAM_AW'(ofs) + VRAM_AW'(SEG_DEPTH)) : VRAM_AW'(ofs);
  endfunction

  // All-off has priority over all-on; otherwise the stored dot passes through
  function automatic logic pix_override(input logic aloff, input logic alon, input logic raw);
    return aloff ? 1'b0 : (alon ? 1'b1 : raw);
  endfunction

  function automatic logic [ICON_W-1:0] icon_override(input logic aloff, input logic alon,
                                                       input logic [ICON_W-1:0] raw);
    return aloff ? '0 : (alon ? '1 : raw);
  endfunction

endpackage

// File: rtl/lcd_vram.sv
// Display RAM, 160 x 4: one bus write port, two synchronous read ports.
// Latency: 1 cycle on both read ports; a same-cycle write is not visible (read-before-write).
// Backpressure: none; port B only updates when its enable is high so held data stays stable.
module lcd_vram
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               wr_en_i,
  input  logic [VRAM_AW-1:0] wr_addr_i,
  input  logic [NIB_W-1:0]   wr_data_i,
  input  logic [VRAM_AW-1:0] rda_addr_i,
  output logic [NIB_W-1:0]   rda_data_o,
  input  logic               rdb_en_i,
  input  logic [VRAM_AW-1:0] rdb_addr_i,
  output logic [NIB_W-1:0]   rdb_data_o
);

  logic [NIB_W-1:0] mem_q [VRAM_DEPTH];
  logic [NIB_W-1:0] rda_q;
  logic [NIB_W-1:0] rdb_q;

  // Storage and both read ports; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rda_q <= mem_q[rda_addr_i];
    if (rdb_en_i) begin
      rdb_q <= mem_q[rdb_addr_i];
    end
  end

  assign rda_data_o = rda_q;
  assign rdb_data_o = rdb_q;

endmodule

// File: rtl/lcd_controller.sv
// LCD controller: bus-mapped display RAM + control reg, 32x16 raster scan out, icon export.
// Latency: bus read data one cycle after address; one pixel per two cycles when pixel_ready is high.
// Backpressure: pixel_valid/x/y/on hold while pixel_ready is low. Macro LCD_READBACK_EN enables VRAM reads.
module lcd_controller
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [11:0]       memory_addr,
  input  logic              memory_write_en,
  input  logic [NIB_W-1:0]  memory_write_data,
  output logic [NIB_W-1:0]  read_data,
  output logic              read_hit,
  input  logic              start_frame,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic [X_W-1:0]    pixel_x,
  output logic [Y_W-1:0]    pixel_y,
  output logic              pixel_on,
  output logic              frame_done,
  output logic [ICON_W-1:0] icons
);

  // ---------------------------------------------------------------- bus decode
  vram_dec_t          bus_dec;
  logic [VRAM_AW-1:0] bus_idx;
  logic               ctrl_sel;
  logic               vram_we;
  logic               rb_hit;

  assign bus_dec  = decode_vram(memory_addr);
  assign bus_idx  = vram_index(bus_dec.seg, bus_dec.ofs);
  assign ctrl_sel = (memory_addr == CTRL_ADDR);
  assign vram_we  = memory_write_en && bus_dec.hit;

`ifdef LCD_READBACK_EN
  assign rb_hit = bus_dec.hit;
`else
  // Display RAM is write-only from the bus side
  assign rb_hit = 1'b0;
`endif

  // ---------------------------------------------------------------- registers
  logic [NIB_W-1:0]  ctrl_q;
  logic [ICON_W-1:0] icon_raw_q;
  logic              rd_vram_sel_q;
  logic              read_hit_q;
  logic [NIB_W-1:0]  rd_ctrl_q;

  lcd_state_e        state_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              valid_q;
  logic              done_q;
  logic [ICON_W-1:0] icons_q;
  logic              mode_aloff_q;
  logic              mode_alon_q;

  logic [NIB_W-1:0]   rda_data;
  logic [NIB_W-1:0]   rdb_data;
  logic [VRAM_AW-1:0] scan_idx;
  logic               scan_fetch;

  // Control register: bus writable, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (memory_write_en && ctrl_sel) begin
      ctrl_q <= memory_write_data;
    end
  end

  // Shadow of the two icon nibbles so the frame end can latch all 8 bits at
  // once without a second VRAM port; like VRAM it is not cleared by reset.
  always_ff @(posedge clk) begin
    if (vram_we && !bus_dec.seg && (bus_dec.ofs == ICON_LO_OFS)) begin
      icon_raw_q[3:0] <= memory_write_data;
    end
    if (vram_we && !bus_dec.seg && (bus_dec.ofs == ICON_HI_OFS)) begin
      icon_raw_q[7:4] <= memory_write_data;
    end
  end

  // Read response pipeline: hit and source select are captured with the address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vram_sel_q <= 1'b0;
      read_hit_q    <= 1'b0;
      rd_ctrl_q     <= '0;
    end else begin
      rd_vram_sel_q <= rb_hit;
      read_hit_q    <= rb_hit || ctrl_sel;
      rd_ctrl_q     <= ctrl_sel ? ctrl_q : '0;
    end
  end

  assign read_data = rd_vram_sel_q ? rda_data : rd_ctrl_q;
  assign read_hit  = read_hit_q;

  // ---------------------------------------------------------------- VRAM
  // Scan address: a nibble holds four vertically adjacent dots of one column
  assign scan_idx   = vram_index(y_q[3], {1'b0, x_q, y_q[2]});
  assign scan_fetch = (state_q == FETCH);

  lcd_vram u_vram (
    .clk        (clk),
    .wr_en_i    (vram_we),
    .wr_addr_i  (bus_idx),
    .wr_data_i  (memory_write_data),
    .rda_addr_i (bus_idx),
    .rda_data_o (rda_data),
    .rdb_en_i   (scan_fetch),
    .rdb_addr_i (scan_idx),
    .rdb_data_o (rdb_data)
  );

  // Scan FSM: raster walk, x fastest; each pixel costs one fetch and one emit cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      icons_q      <= '0;
      mode_aloff_q <= 1'b0;
      mode_alon_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_frame) begin
            x_q     <= '0;
            y_q     <= '0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // Override mode is frozen with the dot so a held pixel cannot change
          mode_aloff_q <= ctrl_q[CTRL_ALOFF];
          mode_alon_q  <= ctrl_q[CTRL_ALON];
          valid_q      <= 1'b1;
          state_q      <= EMIT;
        end
        EMIT: begin
          if (pixel_ready) begin
            valid_q <= 1'b0;
            x_q     <= x_q + 1'b1;
            if (x_q == X_W'(31)) begin
              y_q     <= y_q + 1'b1;
              state_q <= (y_q == Y_W'(15)) ? ICONS : FETCH;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        ICONS: begin
          icons_q <= icon_override(ctrl_q[CTRL_ALOFF], ctrl_q[CTRL_ALON], icon_raw_q);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Dot select from the fetched nibble; every input here is a register held during EMIT
  assign pixel_on    = valid_q && pix_override(mode_aloff_q, mode_alon_q, rdb_data[y_q[1:0]]);
  assign pixel_valid = valid_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign frame_done  = done_q;
  assign icons       = icons_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: random VRAM content and random pixel_ready.
// Expected pixels come from an image model built from the address-to-dot rules.
// Monitor pops and compares on every accepted pixel, independent of the driver.
module tb_lcd_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] memory_addr;
  logic        memory_write_en;
  logic [3:0]  memory_write_data;
  logic [3:0]  read_data;
  logic        read_hit;
  logic        start_frame;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [4:0]  pixel_x;
  logic [3:0]  pixel_y;
  logic        pixel_on;
  logic        frame_done;
  logic [7:0]  icons;

  lcd_controller dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .memory_addr       (memory_addr),
    .memory_write_en   (memory_write_en),
    .memory_write_data (memory_write_data),
    .read_data         (read_data),
    .read_hit          (read_hit),
    .start_frame       (start_frame),
    .pixel_valid       (pixel_valid),
    .pixel_ready       (pixel_ready),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .pixel_on          (pixel_on),
    .frame_done        (frame_done),
    .icons             (icons)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic       img [0:15][0:31];
  logic [3:0] nib [0:4095];
  logic [7:0] m_icon_raw;
  logic [3:0] m_ctrl;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic       on;
  } pix_t;

  pix_t exp_q [$];

  int n_cmp = 0;
  int n_fail = 0;
  int acc_count = 0;
  int fd_count = 0;
  bit   prev_stall = 1'b0;
  pix_t prev_pix;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input int a, input logic [3:0] d);
    int s;
    int o;
    if ((a >= 'hE00 && a <= 'hE4F) || (a >= 'hE80 && a <= 'hECF)) begin
      s = (a >= 'hE80) ? 1 : 0;
      o = a - ((s == 1) ? 'hE80 : 'hE00);
      nib[a] = d;
      if (o < 64) begin
        for (int b = 0; b < 4; b++) img[8*s + 4*(o % 2) + b][o / 2] = d[b];
      end else if (s == 0 && o == 64) begin
        m_icon_raw[3:0] = d;
      end else if (s == 0 && o == 65) begin
        m_icon_raw[7:4] = d;
      end
    end else if (a == 'hF71) begin
      m_ctrl = d;
    end
  endfunction

  function automatic logic exp_pix(input int x, input int y);
    if (m_ctrl[3]) return 1'b0;
    if (m_ctrl[2]) return 1'b1;
    return img[y][x];
  endfunction

  function automatic logic [7:0] exp_icons();
    if (m_ctrl[3]) return 8'h00;
    if (m_ctrl[2]) return 8'hFF;
    return m_icon_raw;
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    pix_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold", {pixel_valid, pixel_x, pixel_y, pixel_on}, {1'b1, prev_pix});
      end
      if (pixel_valid && pixel_ready) begin
        acc_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pixel_extra: got x=%0d y=%0d on=%0d, required no pixel", pixel_x, pixel_y, pixel_on);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("pixel(%0d,%0d)", e.x, e.y), {pixel_x, pixel_y, pixel_on}, e);
        end
      end
      prev_stall = pixel_valid && !pixel_ready;
      prev_pix   = {pixel_x, pixel_y, pixel_on};
      if (frame_done) fd_count++;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input int a, input logic [3:0] d);
    memory_addr       = 12'(a);
    memory_write_data = d;
    memory_write_en   = 1'b1;
    tick();
    memory_write_en   = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input int a, input logic [3:0] ed, input logic eh, input string name);
    memory_addr     = 12'(a);
    memory_write_en = 1'b0;
    tick();
    @(negedge clk);
    chk({name, "_data"}, read_data, ed);
    chk({name, "_hit"}, read_hit, eh);
  endtask

  task automatic vram_read(input int a, input string name);
`ifdef LCD_READBACK_EN
    bus_read(a, nib[a], 1'b1, name);
`else
    bus_read(a, 4'h0, 1'b0, name);
`endif
  endtask

  task automatic push_frame();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++)
        exp_q.push_back({5'(x), 4'(y), exp_pix(x, y)});
  endtask

  task automatic run_frame(input bit rnd, input bit inject, input string name);
    int fd0 = fd_count;
    int acc0 = acc_count;
    bit done = 1'b0;
    logic [7:0] ei;
    push_frame();
    ei = exp_icons();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    for (int c = 0; c < 6000 && !done; c++) begin
      pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_frame = inject && (acc_count - acc0 >= 20) && (acc_count - acc0 < 400) && (c % 37 == 5);
      tick();
      done = (fd_count != fd0);
    end
    start_frame = 1'b0;
    pixel_ready = 1'b1;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no frame_done, required one within budget", name);
    end
    repeat (20) tick();
    @(negedge clk);
    chk({name, "_frame_done_count"}, fd_count - fd0, 1);
    chk({name, "_pixels_left"}, exp_q.size(), 0);
    chk({name, "_icons"}, icons, ei);
    chk({name, "_idle_valid"}, pixel_valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    int fd0;
    int acc0;
    bit hit100;
    reset_n           = 1'b0;
    memory_addr       = 12'h000;
    memory_write_en   = 1'b0;
    memory_write_data = 4'h0;
    start_frame       = 1'b0;
    pixel_ready       = 1'b1;
    m_ctrl            = 4'h0;
    m_icon_raw        = 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", pixel_valid, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_icons", icons, 8'h00);
    chk("rst_xyon", {pixel_x, pixel_y, pixel_on}, 10'h000);
    chk("rst_read", {read_hit, read_data}, 5'h00);
    reset_n = 1'b1;
    tick();

    // Fill both segments, then the directed values
    for (int s = 0; s < 2; s++)
      for (int o = 0; o < 80; o++)
        bus_write(((s == 1) ? 'hE80 : 'hE00) + o, 4'($urandom_range(0, 15)));
    bus_write('hE00, 4'h5);
    bus_write('hE01, 4'hA);
    bus_write('hE81, 4'h8);
    bus_write('hE40, 4'h3);
    bus_write('hE41, 4'hC);
    bus_write('hE55, 4'hF);
    bus_write('hED0, 4'hF);

    vram_read('hE00, "rd_e00");
    vram_read('hE41, "rd_e41");
    vram_read('hEC7, "rd_ec7");
    bus_read('hE55, 4'h0, 1'b0, "rd_e55");
    bus_read('hF71, 4'h0, 1'b1, "rd_ctrl0");

    run_frame(1'b0, 1'b0, "f1");
    chk("f1_icons_c3", icons, 8'hC3);

    // Fresh random content, random backpressure, stray start_frame pulses
    for (int i = 0; i < 160; i++)
      bus_write(((i >= 80) ? 'hE80 : 'hE00) + (i % 80), 4'($urandom_range(0, 15)));
    run_frame(1'b1, 1'b1, "f2");

    bus_write('hF71, 4'h4);
    run_frame(1'b0, 1'b0, "f_alon");
    bus_write('hF71, 4'hC);
    bus_read('hF71, 4'hC, 1'b1, "rd_ctrlc");
    run_frame(1'b1, 1'b0, "f_aloff");
    bus_write('hF71, 4'h1);

    // Reset in the middle of a frame
    fd0 = fd_count;
    acc0 = acc_count;
    hit100 = 1'b0;
    push_frame();
    start_frame = 1'b1;
    tick();
    start_frame = 1'b0;
    for (int c = 0; c < 1000 && !hit100; c++) begin
      tick();
      hit100 = (acc_count - acc0 >= 100);
    end
    if (!hit100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL abort_timeout: got %0d pixels, required 100", acc_count - acc0);
    end
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("abort_valid", pixel_valid, 1'b0);
    chk("abort_done", frame_done, 1'b0);
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    m_ctrl = 4'h0;
    repeat (10) tick();
    @(negedge clk);
    chk("abort_no_frame_done", fd_count - fd0, 0);
    chk("abort_icons", icons, 8'h00);
    bus_read('hF71, 4'h0, 1'b1, "rd_ctrl_after_rst");
    run_frame(1'b1, 1'b0, "f_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
